// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: immediate format codes, opcodes used by the
// li expansion, and signed range limits for each immediate format.
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_R   = 3'b101,
    IMM_RAW = 3'b110
  } imm_op_e;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam int I_MIN = -2048;
  localparam int I_MAX = 2047;
  localparam int B_MIN = -4096;
  localparam int B_MAX = 4094;
  localparam int J_MIN = -1048576;
  localparam int J_MAX = 1048574;

  function automatic logic in_range(logic [31:0] v, int lo, int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational placement of immediate and register fields into one instruction
// word, with range (err[0]) and alignment (err[1]) flags.
module imm_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  output logic [31:0] inst,
  output logic [1:0]  err
);

  always_comb begin
    inst = '0;
    err  = '0;
    case (op)
      IMM_I: begin
        inst   = {imm[11:0], rs1, funct3, rd, opcode};
        err[0] = !in_range(imm, I_MIN, I_MAX);
      end
      IMM_S: begin
        inst   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err[0] = !in_range(imm, I_MIN, I_MAX);
      end
      IMM_B: begin
        inst   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err[0] = !in_range(imm, B_MIN, B_MAX);
        err[1] = imm[0];
      end
      IMM_U: begin
        inst   = {imm[31:12], rd, opcode};
        err[1] = |imm[11:0];
      end
      IMM_J: begin
        inst   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err[0] = !in_range(imm, J_MIN, J_MAX);
        err[1] = imm[0];
      end
      IMM_R: begin
        inst = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      default: begin
        inst = imm;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Instruction assembler with valid/ready stream in and out; expands li into
// LUI+ADDI when the constant does not fit a single instruction.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_EMPTY | no word held, out_valid_o low
// ST_LAST  | holding a single word or the final ADDI of a pair
// ST_FIRST | holding the LUI of a pair, ADDI waiting in pend_q
module imm_encoder
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  imm_op_i,
  input  logic        li_en_i,
  input  logic [31:0] imm_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [6:0]  funct7_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] inst_o,
  output logic [1:0]  err_o
);

  typedef enum logic [1:0] {ST_EMPTY, ST_LAST, ST_FIRST} state_e;

  state_e      state;
  logic [31:0] inst_q, pend_q;
  logic [1:0]  err_q;

  logic        accept, li_short, li_pair;
  logic [19:0] hi;
  logic [31:0] lui_word;

  logic [2:0]  p_op;
  logic [31:0] p_imm;
  logic [6:0]  p_opcode;
  logic [2:0]  p_funct3;
  logic [4:0]  p_rs1;
  logic [31:0] pack_inst;
  logic [1:0]  pack_err;

  assign in_ready_o  = (state == ST_EMPTY) | ((state == ST_LAST) & out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state != ST_EMPTY);
  assign inst_o      = inst_q;
  assign err_o       = err_q;

  // Rounding the upper part by imm[11] compensates for ADDI sign-extending lo.
  assign li_short = in_range(imm_i, I_MIN, I_MAX);
  assign li_pair  = !li_short && (imm_i[11:0] != 12'd0);
  assign hi       = imm_i[31:12] + {19'd0, imm_i[11]};
  assign lui_word = {hi, rd_i, OPC_LUI};

  // The packer builds the ADDI half during li; rs1 is x0 unless it follows a LUI.
  always_comb begin
    p_op     = imm_op_i;
    p_imm    = imm_i;
    p_opcode = opcode_i;
    p_funct3 = funct3_i;
    p_rs1    = rs1_i;
    if (li_en_i) begin
      p_op     = IMM_I;
      p_imm    = {{20{imm_i[11]}}, imm_i[11:0]};
      p_opcode = OPC_OPIMM;
      p_funct3 = 3'b000;
      p_rs1    = li_pair ? rd_i : 5'd0;
    end
  end

  imm_pack u_pack (
    .op     (p_op),
    .imm    (p_imm),
    .opcode (p_opcode),
    .rd     (rd_i),
    .funct3 (p_funct3),
    .rs1    (p_rs1),
    .rs2    (rs2_i),
    .funct7 (funct7_i),
    .inst   (pack_inst),
    .err    (pack_err)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_EMPTY;
      inst_q <= '0;
      err_q  <= '0;
      pend_q <= '0;
    end else if (accept) begin
      if (li_en_i) begin
        err_q  <= 2'b00;
        inst_q <= li_short ? pack_inst : lui_word;
        if (li_pair) begin
          pend_q <= pack_inst;
          state  <= ST_FIRST;
        end else begin
          state <= ST_LAST;
        end
      end else begin
        inst_q <= pack_inst;
        err_q  <= pack_err;
        state  <= ST_LAST;
      end
    end else if (out_ready_i) begin
      case (state)
        ST_FIRST: begin
          inst_q <= pend_q;
          err_q  <= 2'b00;
          state  <= ST_LAST;
        end
        ST_LAST: state <= ST_EMPTY;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized checks of imm_encoder against an arithmetic encoding
// model and an independent immediate decoder.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, li_en, out_valid, out_ready;
  logic [2:0]  imm_op, funct3;
  logic [31:0] imm, inst;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  err;

  int n_chk  = 0;
  int n_fail = 0;
  bit [33:0] expq[$];
  bit [31:0] got[$];

  imm_encoder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .imm_op_i    (imm_op),
    .li_en_i     (li_en),
    .imm_i       (imm),
    .opcode_i    (opcode),
    .rd_i        (rd),
    .funct3_i    (funct3),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .funct7_i    (funct7),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .inst_o      (inst),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Encoding model: fields shifted into position with masks, range checked on integers.
  function automatic bit [33:0] model(input int unsigned op, input bit [31:0] v,
      input bit [31:0] opc, input bit [31:0] r_d, input bit [31:0] f3,
      input bit [31:0] r_s1, input bit [31:0] r_s2, input bit [31:0] f7);
    longint s = $signed(v);
    bit [31:0] w = 0;
    bit [1:0]  e = 0;
    case (op)
      0: begin
        w = (v & 32'hFFF) << 20 | r_s1 << 15 | f3 << 12 | r_d << 7 | opc;
        e[0] = (s < -2048 || s > 2047);
      end
      1: begin
        w = ((v >> 5) & 32'h7F) << 25 | r_s2 << 20 | r_s1 << 15 | f3 << 12
            | (v & 32'h1F) << 7 | opc;
        e[0] = (s < -2048 || s > 2047);
      end
      2: begin
        w = ((v >> 12) & 1) << 31 | ((v >> 5) & 32'h3F) << 25 | r_s2 << 20 | r_s1 << 15
            | f3 << 12 | ((v >> 1) & 32'hF) << 8 | ((v >> 11) & 1) << 7 | opc;
        e[0] = (s < -4096 || s > 4094);
        e[1] = (v % 2) != 0;
      end
      3: begin
        w = (v & 32'hFFFFF000) | r_d << 7 | opc;
        e[1] = (v % 4096) != 0;
      end
      4: begin
        w = ((v >> 20) & 1) << 31 | ((v >> 1) & 32'h3FF) << 21 | ((v >> 11) & 1) << 20
            | ((v >> 12) & 32'hFF) << 12 | r_d << 7 | opc;
        e[0] = (s < -1048576 || s > 1048574);
        e[1] = (v % 2) != 0;
      end
      5: w = f7 << 25 | r_s2 << 20 | r_s1 << 15 | f3 << 12 | r_d << 7 | opc;
      default: w = v;
    endcase
    return {e, w};
  endfunction

  // Reverse direction (what immgen would return) for round-trip checks.
  function automatic bit [31:0] decode(input bit [31:0] w, input int unsigned op);
    case (op)
      0: return {{20{w[31]}}, w[31:20]};
      1: return {{20{w[31]}}, w[31:25], w[11:7]};
      2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3: return {w[31:12], 12'd0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  task automatic li_model(input bit [31:0] v, input bit [31:0] r_d);
    longint    s  = $signed(v);
    bit [31:0] lo = ((v & 32'hFFF) ^ 32'h800) - 32'h800;
    bit [31:0] lw = ((v + 32'h800) & 32'hFFFFF000) | r_d << 7 | 32'h37;
    if (s >= -2048 && s <= 2047) begin
      expq.push_back(model(0, lo, 32'h13, r_d, 0, 0, 0, 0));
    end else if ((v & 32'hFFF) == 0) begin
      expq.push_back({2'b00, lw});
    end else begin
      expq.push_back({2'b00, lw});
      expq.push_back(model(0, lo, 32'h13, r_d, 0, r_d, 0, 0));
    end
  endtask

  task automatic drive(input int unsigned op, input bit li, input bit [31:0] v,
      input bit [6:0] opc, input bit [4:0] r_d, input bit [2:0] f3,
      input bit [4:0] r_s1, input bit [4:0] r_s2, input bit [6:0] f7);
    imm_op = op[2:0]; li_en = li; imm = v; opcode = opc; rd = r_d;
    funct3 = f3; rs1 = r_s1; rs2 = r_s2; funct7 = f7;
    in_valid = 1'b1;
  endtask

  // Called at posedge+1; leaves the DUT holding the last word in LAST.
  task automatic do_req(input int unsigned op, input bit li, input bit [31:0] v,
      input bit [6:0] opc, input bit [4:0] r_d, input bit [2:0] f3,
      input bit [4:0] r_s1, input bit [4:0] r_s2, input bit [6:0] f7);
    bit [33:0] e;
    got.delete();
    expq.delete();
    if (li) li_model(v, {27'd0, r_d});
    else    expq.push_back(model(op, v, {25'd0, opc}, {27'd0, r_d}, {29'd0, f3},
                                 {27'd0, r_s1}, {27'd0, r_s2}, {25'd0, f7}));
    out_ready = 1'b1;
    drive(op, li, v, opc, r_d, f3, r_s1, r_s2, f7);
    #1 chk("in_ready_open", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got.push_back(inst);
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("inst", inst, e[31:0]);
      chk("err", {30'd0, err}, {30'd0, e[33:32]});
      if (!li && op < 5 && e[33:32] == 2'b00)
        chk("roundtrip", decode(inst, op), v);
      if (expq.size() > 0) begin
        chk("in_ready_first", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int bnd[7];
    bit [31:0] hold_w, v;
    bit [33:0] eb;
    bnd = '{2047, -2048, 4094, -4096, 1048574, -1048576, 0};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_err", {30'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // I-type and B-type examples
    do_req(0, 0, 32'hFFFFFFFF, 7'h13, 5, 0, 6, 0, 0);
    chk("i_word", got[0], 32'hFFF30293);
    chk("i_immgen", decode(got[0], 0), 32'hFFFFFFFF);
    do_req(2, 0, 32'hFFFFF000, 7'h63, 0, 0, 1, 2, 0);
    chk("b_word", got[0], 32'h80208063);
    do_req(2, 0, 32'd4096, 7'h63, 0, 0, 1, 2, 0);
    chk("b_range", {30'd0, err}, 32'd1);
    do_req(2, 0, 32'd3, 7'h63, 0, 0, 1, 2, 0);
    chk("b_align", {30'd0, err}, 32'd2);

    // li expansion forms; opcode/funct3/rs1 junk must be ignored
    do_req(5, 1, 32'h12345FFF, 7'h7F, 1, 3'h7, 5'h1F, 0, 0);
    chk("li_pair_n", got.size(), 2);
    chk("li_lui", got[0], 32'h123460B7);
    chk("li_addi", got[1], 32'hFFF08093);
    do_req(2, 1, 32'h7FF, 7'h55, 1, 3'h5, 5'h9, 0, 0);
    chk("li_small", got[0], 32'h7FF00093);
    do_req(0, 1, 32'h10000, 7'h55, 1, 3'h5, 5'h9, 0, 0);
    chk("li_lui_only", got[0], 32'h000100B7);

    // backpressure with a waiting request, then a bubble-free swap
    do_req(0, 0, 32'd100, 7'h13, 7, 1, 8, 0, 0);
    hold_w = got[0];
    eb = model(1, 32'hFFFFFF80, 32'h23, 0, 2, 3, 4, 0);
    out_ready = 1'b0;
    drive(1, 0, 32'hFFFFFF80, 7'h23, 0, 2, 3, 4, 0);
    repeat (3) begin
      #1 chk("bp_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_inst", inst, hold_w);
      chk("bp_err", {30'd0, err}, 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_swap_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_swap_inst", inst, eb[31:0]);

    // reset in FIRST drops the pending ADDI
    drive(0, 1, 32'h12345FFF, 0, 3, 0, 0, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pre_rst_lui", inst, 32'h123461B7);
    rst = 1'b1;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_inst", inst, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("no_addi", {31'd0, out_valid}, 32'd0);
    end
    do_req(4, 0, 32'd2048, 7'h6F, 9, 0, 0, 0, 0);

    // randomized requests with occasional output stalls
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = bnd[$urandom_range(0, 6)] + $urandom_range(0, 2) - 1;
        2: v = $urandom & 32'hFFFFF000;
        default: v = $urandom_range(0, 8191) - 4096;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        hold_w = got[got.size()-1];
        out_ready = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_inst", inst, hold_w);
        end
      end
      do_req($urandom_range(0, 7), ($urandom_range(0, 3) == 0), v, 7'($urandom),
             5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 7'($urandom));
    end
    @(posedge clk); #1;
    chk("drain", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined RISC-V instruction assembler: the inverse of `immgen`, packing an immediate plus register/function fields into a 32-bit instruction word per the imm_op type code. It optionally expands a load-immediate request into a LUI+ADDI pair. It sits in the boot/patch path and the self-test stimulus generator, feeding instruction memory writes over a valid/ready stream. It also flags immediates that cannot be represented in the selected format.

## Interface
Parameters: none.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: request accepted when valid & ready.
- `imm_op_i` in 3: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R, 110/111 raw.
- `li_en_i` in 1: treat request as `li rd, imm`; opcode/funct3/rs1 inputs ignored.
- `imm_i` in 32: immediate, two's complement; raw word for 110/111.
- `opcode_i` in 7, `rd_i` in 5, `funct3_i` in 3, `rs1_i` in 5, `rs2_i` in 5, `funct7_i` in 7: fields.
- `out_valid_o` out 1: instruction valid.
- `out_ready_i` in 1: consumer accepts when valid & ready.
- `inst_o` out 32: assembled instruction.
- `err_o` out 2: [0] range overflow, [1] misaligned (imm[0]≠0 for B/J, imm[11:0]≠0 for U).

## Operation
- Bit placement mirrors decode exactly:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - R: [31:25]=funct7, [24:20]=rs2.
  - Raw: inst=imm_i, all other fields ignored, err=0.
- Fields are placed only where the type has them:
  - opcode [6:0] always, except raw.
  - rd [11:7] for I/U/J/R.
  - funct3 [14:12] for I/S/B/R.
  - rs1 [19:15] for I/S/B/R.
  - rs2 [24:20] for S/B/R.
- Signed range checks set err_o[0]: I/S [-2048,2047]; B [-4096,4094]; J [-1048576,1048574]. U and R never set it.
- On error the word is still emitted with the immediate truncated to the placed bits.
- li expansion (li_en_i=1; imm_op_i is don't-care):
  - lo = sign-extended imm[11:0]; hi = (imm_i + 0x800)[31:12], 32-bit wrap.
  - imm in [-2048,2047]: single ADDI (opcode 0010011, funct3 000, rs1=x0, rd).
  - Else if imm[11:0]==0: single LUI (opcode 0110111, rd, hi).
  - Else: LUI rd,hi then ADDI rd,rd,lo. err_o=0 for both words.
- States:
  - EMPTY: out_valid_o=0.
  - LAST: holding a single or final word.
  - FIRST: holding a LUI with the ADDI pending in an internal register.
- Transitions:
  - EMPTY/LAST accept → FIRST for a two-word li; otherwise LAST.
  - LAST with out_ready_i and no accept → EMPTY.
  - FIRST with out_ready_i → LAST, ADDI loaded into inst_o.

## Timing
- Reset values: out_valid_o=0, inst_o=0, err_o=0, state EMPTY, pending ADDI cleared.
- Latency: 1 cycle from accept to out_valid_o.
- Throughput: 1 word/cycle; a two-word li occupies 2 output cycles.
- in_ready_o = (state==EMPTY) | (state==LAST & out_ready_i). It is combinational from out_ready_i and the registered state, and is 0 in FIRST.
- inst_o and err_o are stable while out_valid_o & !out_ready_i; no data change under backpressure.
- A simultaneous output handshake and input accept in LAST replaces the word in the same edge, with no bubble.
- in_valid_i may drop without acceptance; no request state is captured before the handshake.
- Reset asserted mid-pair discards the pending ADDI; the outputs go to reset values immediately (async).

## Structure
- Shared `riscv_pkg` holds:
  - `imm_op_e` enum (IMM_I..IMM_R, IMM_RAW), shared with immgen.
  - Opcode constants OPC_LUI=0110111, OPC_OPIMM=0010011.
  - Range limit localparams.
- Sub-module `imm_pack`: purely combinational field placement plus error flags for one word. It is instantiated once and used for both the normal path and the ADDI half.
- The top level holds the FSM, output register, pending ADDI register and li split arithmetic.

## Test plan
- I-type: imm=-1, rd=5, rs1=6, funct3=0, opcode 0010011 → inst 0xFFF30293, err 00. Feeding the word back into immgen returns 0xFFFFFFFF.
- B-type: imm=-4096, rs1=1, rs2=2, funct3=0, opcode 1100011 → 0x80208063, err 00. With imm=4096 the range flag is set, err 01; with imm=3 the misaligned flag is set, err 10.
- li x1,0x12345FFF → two words LUI 0x123460B7, then ADDI 0xFFF08093. in_ready_o is 0 in between.
- li x1,0x7FF → one ADDI 0x7FF00093. li x1,0x10000 → one LUI 0x000100B7.
- Backpressure: hold out_ready_i=0 for 3 cycles with in_valid_i=1 → inst_o is unchanged and no accept occurs. When out_ready_i=1, the next request is accepted in the same cycle with no bubble.
- Assert rst_i during FIRST → out_valid_o=0 next sample and no ADDI is emitted. The first request after reset appears 1 cycle after accept.
